// File: rtl/hilo_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hilo_pkg
// Purpose  : Shared encodings for the HI/LO control stage: FSM state codes,
//            operation select values and the default arithmetic latency.
// Revision : 1.0 - initial release
// ============================================================================
package hilo_pkg;

  // 3-bit state codes for the HI/LO sequencer
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_RUN     = 3'd2;
  localparam logic [2:0] ST_CAPTURE = 3'd3;
  localparam logic [2:0] ST_EXC     = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE    = ST_IDLE,
    S_LOAD    = ST_LOAD,
    S_RUN     = ST_RUN,
    S_CAPTURE = ST_CAPTURE,
    S_EXC     = ST_EXC
  } hilo_state_t;

  // Operation select carried on the op input
  localparam logic OP_MULT = 1'b0;
  localparam logic OP_DIV  = 1'b1;

  // Cycles the div/mult units need after their restart pulse
  localparam int HILO_LATENCY_DEFAULT = 33;

endpackage : hilo_pkg
`default_nettype wire

// File: rtl/hilo_regs.sv
`default_nettype none
// ============================================================================
// Module   : hilo_regs
// Purpose  : Architectural HI/LO register pair. A result capture loads both
//            halves at once; otherwise mthi/mtlo strobes write wdata into
//            either or both registers.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_regs (
  input  logic        clock,
  input  logic        reset,
  input  logic        capture_en,
  input  logic [63:0] result,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // HI/LO storage: capture has priority, the controller never overlaps the two
  always_ff @(posedge clock) begin
    if (reset) begin
      hi <= 32'd0;
      lo <= 32'd0;
    end else if (capture_en) begin
      hi <= result[63:32];
      lo <= result[31:0];
    end else begin
      if (mthi) hi <= wdata;
      if (mtlo) lo <= wdata;
    end
  end

endmodule : hilo_regs
`default_nettype wire

// File: rtl/hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hilo_ctrl
// Purpose  : HI/LO control stage for the multi-cycle MIPS datapath. Latches
//            mult/div operands, restarts the arithmetic units, waits out
//            their fixed latency, captures the selected result into HI/LO,
//            flags division by zero and services mthi/mtlo writes.
// Revision : 1.0 - initial release
// ============================================================================
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int LATENCY = HILO_LATENCY_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] rs_data,
  input  logic [31:0] rt_data,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic [31:0] wdata,
  input  logic [31:0] hi_div,
  input  logic [31:0] lo_div,
  input  logic        division_by_zero,
  input  logic [31:0] hi_mult,
  input  logic [31:0] lo_mult,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        unit_reset,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        div_zero_exc
);

  // Counter must hold values 0 .. LATENCY
  localparam int            CNT_W    = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  hilo_state_t      r_state;
  hilo_state_t      w_next;
  logic [CNT_W-1:0] r_count;
  logic             r_op;
  logic [31:0]      r_op_a;
  logic [31:0]      r_op_b;
  logic             r_done;
  logic             r_exc;

  logic             w_accept;
  logic             w_cnt_clr;
  logic             w_cnt_inc;
  logic             w_capture;
  logic             w_done_d;
  logic             w_exc_d;
  logic             w_unit_reset;
  logic             w_idle;
  logic [63:0]      w_result;

  assign w_idle   = (r_state == S_IDLE);
  assign w_result = (r_op == OP_DIV) ? {hi_div, lo_div} : {hi_mult, lo_mult};

  // Next-state and per-state control strobes
  always_comb begin
    w_next       = r_state;
    w_accept     = 1'b0;
    w_cnt_clr    = 1'b0;
    w_cnt_inc    = 1'b0;
    w_capture    = 1'b0;
    w_done_d     = 1'b0;
    w_exc_d      = 1'b0;
    w_unit_reset = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_accept = 1'b1;
          w_next   = S_LOAD;
        end
      end
      S_LOAD: begin
        w_unit_reset = 1'b1;
        // A zero divisor is known from the latched operand, so skip the wait
        if ((r_op == OP_DIV) && (r_op_b == 32'd0)) begin
          w_next = S_EXC;
        end else begin
          w_cnt_clr = 1'b1;
          w_next    = S_RUN;
        end
      end
      S_RUN: begin
        w_cnt_inc = 1'b1;
        if (r_count == CNT_LAST) w_next = S_CAPTURE;
      end
      S_CAPTURE: begin
        w_done_d = 1'b1;
        w_next   = S_IDLE;
        // The divider's own zero flag still suppresses the write-back
        if ((r_op == OP_DIV) && division_by_zero) w_exc_d = 1'b1;
        else                                      w_capture = 1'b1;
      end
      S_EXC: begin
        w_done_d = 1'b1;
        w_exc_d  = 1'b1;
        w_next   = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, counter, operand latches and registered completion pulses
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_count <= '0;
      r_op    <= OP_MULT;
      r_op_a  <= 32'd0;
      r_op_b  <= 32'd0;
      r_done  <= 1'b0;
      r_exc   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op   <= op;
        r_op_a <= rs_data;
        r_op_b <= rt_data;
      end
      if (w_cnt_clr)      r_count <= '0;
      else if (w_cnt_inc) r_count <= r_count + CNT_W'(1);
      r_done <= w_done_d;
      r_exc  <= w_exc_d;
    end
  end

  hilo_regs u_regs (
    .clock      (clock),
    .reset      (reset),
    .capture_en (w_capture),
    .result     (w_result),
    .mthi       (mthi && w_idle),
    .mtlo       (mtlo && w_idle),
    .wdata      (wdata),
    .hi         (hi),
    .lo         (lo)
  );

  assign op_a         = r_op_a;
  assign op_b         = r_op_b;
  assign unit_reset   = w_unit_reset;
  assign busy         = !w_idle;
  assign done         = r_done;
  assign div_zero_exc = r_exc;

endmodule : hilo_ctrl
`default_nettype wire

// File: tb/tb_hilo_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hilo_ctrl
// Purpose  : Directed self-checking bench for hilo_ctrl with behavioural
//            div/mult units driven from the latched operands.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_ctrl;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] rs_data = 32'd0;
  logic [31:0] rt_data = 32'd0;
  logic        mthi = 1'b0;
  logic        mtlo = 1'b0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] hi_div, lo_div, hi_mult, lo_mult;
  logic        division_by_zero;
  logic [31:0] op_a, op_b, hi, lo;
  logic        unit_reset, busy, done, div_zero_exc;
  logic [63:0] prod;

  int n_checks = 0;
  int n_pass   = 0;

  hilo_ctrl #(.LATENCY(33)) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .op               (op),
    .rs_data          (rs_data),
    .rt_data          (rt_data),
    .mthi             (mthi),
    .mtlo             (mtlo),
    .wdata            (wdata),
    .hi_div           (hi_div),
    .lo_div           (lo_div),
    .division_by_zero (division_by_zero),
    .hi_mult          (hi_mult),
    .lo_mult          (lo_mult),
    .op_a             (op_a),
    .op_b             (op_b),
    .unit_reset       (unit_reset),
    .hi               (hi),
    .lo               (lo),
    .busy             (busy),
    .done             (done),
    .div_zero_exc     (div_zero_exc)
  );

  always #5 clock = ~clock;

  // Behavioural stand-ins for the div and mult units (unsigned)
  always_comb begin
    division_by_zero = (op_b == 32'd0);
    hi_div  = division_by_zero ? 32'd0 : (op_a % op_b);
    lo_div  = division_by_zero ? 32'd0 : (op_a / op_b);
    prod    = {32'd0, op_a} * {32'd0, op_b};
    hi_mult = prod[63:32];
    lo_mult = prod[31:0];
  end

  // Advance n rising edges, returning 1 time unit after the last one
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  // Present a start request; returns in cycle 1 with request inputs scrambled
  task automatic launch(input logic o, input logic [31:0] a, input logic [31:0] b);
    op = o; rs_data = a; rt_data = b; start = 1'b1;
    step(1);
    start = 1'b0; op = ~o; rs_data = 32'hDEAD_BEEF; rt_data = 32'hFFFF_FFFF;
  endtask

  task automatic test_reset();
    n_checks++;
    if ({hi, lo, op_a, op_b} !== 128'd0)
      $display("FAIL reset_data: got hi=%h lo=%h op_a=%h op_b=%h expected all 0", hi, lo, op_a, op_b);
    else n_pass++;
    n_checks++;
    if ({busy, done, div_zero_exc, unit_reset} !== 4'b0000)
      $display("FAIL reset_ctrl: got busy/done/exc/ureset=%b expected 0000", {busy, done, div_zero_exc, unit_reset});
    else n_pass++;
  endtask

  task automatic test_divide();
    launch(1'b1, 32'd100, 32'd7);
    n_checks++;
    if ({busy, unit_reset} !== 2'b11)
      $display("FAIL div_load: got busy/ureset=%b expected 11", {busy, unit_reset});
    else n_pass++;
    step(1);  // cycle 2
    n_checks++;
    if ({busy, unit_reset, op_a, op_b} !== {2'b10, 32'd100, 32'd7})
      $display("FAIL div_run: got busy/ureset=%b op_a=%0d op_b=%0d expected 10 100 7", {busy, unit_reset}, op_a, op_b);
    else n_pass++;
    step(33); // cycle 35
    n_checks++;
    if ({busy, done} !== 2'b10)
      $display("FAIL div_c35: got busy/done=%b expected 10", {busy, done});
    else n_pass++;
    step(1);  // cycle 36
    n_checks++;
    if ({busy, done, div_zero_exc, hi, lo} !== {3'b010, 32'd2, 32'd14})
      $display("FAIL div_result: got busy/done/exc=%b hi=%0d lo=%0d expected 010 2 14", {busy, done, div_zero_exc}, hi, lo);
    else n_pass++;
    step(1);
    n_checks++;
    if (done !== 1'b0)
      $display("FAIL div_done_pulse: got done=%b expected 0", done);
    else n_pass++;
  endtask

  task automatic test_multiply();
    launch(1'b0, 32'h0001_0000, 32'h0001_0000);
    step(35); // cycle 36
    n_checks++;
    if ({busy, done, div_zero_exc, hi, lo} !== {3'b010, 32'h1, 32'h0})
      $display("FAIL mult_result: got busy/done/exc=%b hi=%h lo=%h expected 010 1 0", {busy, done, div_zero_exc}, hi, lo);
    else n_pass++;
  endtask

  task automatic test_mt_idle();
    mthi = 1'b1; wdata = 32'hAAAA_AAAA;
    step(1);
    mthi = 1'b0; mtlo = 1'b1; wdata = 32'h5555_5555;
    n_checks++;
    if (hi !== 32'hAAAA_AAAA)
      $display("FAIL mthi_idle: got hi=%h expected aaaaaaaa", hi);
    else n_pass++;
    step(1);
    mtlo = 1'b0;
    n_checks++;
    if ({hi, lo} !== {32'hAAAA_AAAA, 32'h5555_5555})
      $display("FAIL mtlo_idle: got hi=%h lo=%h expected aaaaaaaa 55555555", hi, lo);
    else n_pass++;
  endtask

  task automatic test_div_zero();
    int ures = 0;
    launch(1'b1, 32'd5, 32'd0);
    if (unit_reset) ures++;
    step(1); // cycle 2
    if (unit_reset) ures++;
    n_checks++;
    if ({busy, done, div_zero_exc} !== 3'b100)
      $display("FAIL dz_c2: got busy/done/exc=%b expected 100", {busy, done, div_zero_exc});
    else n_pass++;
    step(1); // cycle 3
    if (unit_reset) ures++;
    n_checks++;
    if ({busy, done, div_zero_exc, hi, lo} !== {3'b011, 32'hAAAA_AAAA, 32'h5555_5555})
      $display("FAIL dz_c3: got busy/done/exc=%b hi=%h lo=%h expected 011 aaaaaaaa 55555555", {busy, done, div_zero_exc}, hi, lo);
    else n_pass++;
    n_checks++;
    if (ures !== 1)
      $display("FAIL dz_ureset_count: got %0d expected 1", ures);
    else n_pass++;
    step(1);
    n_checks++;
    if ({done, div_zero_exc} !== 2'b00)
      $display("FAIL dz_pulse_end: got done/exc=%b expected 00", {done, div_zero_exc});
    else n_pass++;
  endtask

  task automatic test_start_with_mt();
    // Write lands in the start cycle and survives the exception
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'h0000_0077;
    launch(1'b1, 32'd8, 32'd0);
    mthi = 1'b0; mtlo = 1'b0;
    n_checks++;
    if ({hi, lo} !== {32'h77, 32'h77})
      $display("FAIL start_mt_write: got hi=%h lo=%h expected 77 77", hi, lo);
    else n_pass++;
    step(2); // cycle 3
    n_checks++;
    if ({done, div_zero_exc, hi, lo} !== {2'b11, 32'h77, 32'h77})
      $display("FAIL start_mt_survive: got done/exc=%b hi=%h lo=%h expected 11 77 77", {done, div_zero_exc}, hi, lo);
    else n_pass++;
  endtask

  task automatic test_start_while_busy();
    int ndone = 0;
    int at = 0;
    logic [31:0] hi_at = 32'd0;
    logic [31:0] lo_at = 32'd0;
    launch(1'b1, 32'd100, 32'd7);
    for (int c = 2; c <= 40; c++) begin
      step(1);
      if (c == 10) begin
        start = 1'b1; op = 1'b0; rs_data = 32'd3; rt_data = 32'd4;
      end else if (c == 11) begin
        start = 1'b0;
      end
      if (done) begin
        ndone++; at = c; hi_at = hi; lo_at = lo;
      end
    end
    n_checks++;
    if (ndone !== 1 || at !== 36)
      $display("FAIL busy_start_done: got %0d pulses last at cycle %0d expected 1 at 36", ndone, at);
    else n_pass++;
    n_checks++;
    if ({hi_at, lo_at, op_a, op_b} !== {32'd2, 32'd14, 32'd100, 32'd7})
      $display("FAIL busy_start_data: got hi=%0d lo=%0d op_a=%0d op_b=%0d expected 2 14 100 7", hi_at, lo_at, op_a, op_b);
    else n_pass++;
  endtask

  task automatic test_mt_during_run();
    mthi = 1'b1; wdata = 32'h0000_1234;
    step(1);
    mthi = 1'b0;
    n_checks++;
    if (hi !== 32'h1234)
      $display("FAIL mthi_1234: got hi=%h expected 1234", hi);
    else n_pass++;
    launch(1'b0, 32'd3, 32'd5);
    step(9); // cycle 10
    mthi = 1'b1; mtlo = 1'b1; wdata = 32'hDEAD_0000;
    step(1); // cycle 11
    mthi = 1'b0; mtlo = 1'b0;
    n_checks++;
    if ({hi, lo} !== {32'h1234, 32'd14})
      $display("FAIL mt_busy_dropped: got hi=%h lo=%h expected 1234 e", hi, lo);
    else n_pass++;
    step(25); // cycle 36
    n_checks++;
    if ({done, hi, lo} !== {1'b1, 32'd0, 32'd15})
      $display("FAIL mt_busy_capture: got done=%b hi=%0d lo=%0d expected 1 0 15", done, hi, lo);
    else n_pass++;
  endtask

  task automatic test_reset_mid_run();
    launch(1'b1, 32'd100, 32'd7);
    step(19); // cycle 20
    reset = 1'b1;
    step(1);  // cycle 21
    reset = 1'b0;
    n_checks++;
    if ({hi, lo, op_a, op_b, busy, done, div_zero_exc, unit_reset} !== 132'd0)
      $display("FAIL midrun_reset: got hi=%h lo=%h op_a=%h op_b=%h b/d/e/u=%b expected all 0",
               hi, lo, op_a, op_b, {busy, done, div_zero_exc, unit_reset});
    else n_pass++;
    step(20);
    n_checks++;
    if ({busy, done} !== 2'b00)
      $display("FAIL midrun_discard: got busy/done=%b expected 00", {busy, done});
    else n_pass++;
    launch(1'b1, 32'd9, 32'd3);
    step(35); // cycle 36
    n_checks++;
    if ({done, hi, lo} !== {1'b1, 32'd0, 32'd3})
      $display("FAIL fresh_div: got done=%b hi=%0d lo=%0d expected 1 0 3", done, hi, lo);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    // Presently in a done cycle: a new start must be accepted right away
    launch(1'b0, 32'd7, 32'd6);
    n_checks++;
    if ({busy, unit_reset, op_a, op_b} !== {2'b11, 32'd7, 32'd6})
      $display("FAIL b2b_accept: got busy/ureset=%b op_a=%0d op_b=%0d expected 11 7 6", {busy, unit_reset}, op_a, op_b);
    else n_pass++;
    step(35);
    n_checks++;
    if ({done, hi, lo} !== {1'b1, 32'd0, 32'd42})
      $display("FAIL b2b_result: got done=%b hi=%0d lo=%0d expected 1 0 42", done, hi, lo);
    else n_pass++;
  endtask

  initial begin
    step(2);
    test_reset();
    reset = 1'b0;
    step(1);
    test_divide();
    test_multiply();
    step(1);
    test_mt_idle();
    test_div_zero();
    test_start_with_mt();
    step(1);
    test_start_while_busy();
    test_mt_during_run();
    step(1);
    test_reset_mid_run();
    test_back_to_back();
    step(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_hilo_ctrl
`default_nettype wire
